// File: rtl/regfile_sequencer.sv
// Micro-sequencer for the 4-bit A/B/O register file and ALU: takes one instruction at a
// time, drives register loads and a timed ALU writeback, then offers the O result.
module regfile_sequencer #(
    parameter int EXEC_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [3:0] instr_imm,
    output logic [3:0] reg_a_d,
    output logic [3:0] reg_b_d,
    output logic       lda,
    output logic       ldb,
    output logic       ldo,
    output logic [1:0] alu_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic [7:0] ops_done,
    output logic [2:0] dbg_state
);
    // Both handshakes transfer on a rising edge where valid and ready are high together;
    // a source holds valid and payload until that edge, and ready never depends on valid.

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, WB, OUT} state_t;

    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_LDB = 3'd2;
    localparam logic [2:0] OP_ILL = 3'd7;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       accept;
    logic       is_alu;
    logic       take;

    assign dbg_state = state;

    always_comb begin
        accept     = instr_valid && instr_ready;
        is_alu     = (instr_op >= 3'd3) && (instr_op <= 3'd6);
        take       = out_valid && out_ready;
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (instr_op == OP_LDA || instr_op == OP_LDB)) begin
                    state_next = LOAD;
                end else if (accept && is_alu) begin
                    state_next = EXEC;
                end
            end
            LOAD: state_next = IDLE;
            // The accept edge counts as the issue cycle, so the counter runs to EXEC_LAT
            // and ldo lands EXEC_LAT+1 edges after accept.
            EXEC: begin
                if (cnt == 4'(EXEC_LAT)) begin
                    state_next = WB;
                end
            end
            WB:  state_next = OUT;
            OUT: begin
                if (take) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            instr_ready <= 1'b0;
            lda         <= 1'b0;
            ldb         <= 1'b0;
            ldo         <= 1'b0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
            ops_done    <= '0;
            reg_a_d     <= '0;
            reg_b_d     <= '0;
            alu_op      <= '0;
        end else begin
            state       <= state_next;
            instr_ready <= (state_next == IDLE);
            lda         <= accept && (instr_op == OP_LDA);
            ldb         <= accept && (instr_op == OP_LDB);
            ldo         <= (state_next == WB);
            out_valid   <= (state_next == OUT);
            if (accept && instr_op == OP_LDA) begin
                reg_a_d <= instr_imm;
            end
            if (accept && instr_op == OP_LDB) begin
                reg_b_d <= instr_imm;
            end
            if (accept && is_alu) begin
                alu_op <= 2'(instr_op - 3'd3);
                cnt    <= '0;
            end else if (state == EXEC) begin
                cnt <= cnt + 4'd1;
            end
            if (accept && instr_op == OP_ILL) begin
                err <= 1'b1;
            end
            if (state == OUT && take) begin
                ops_done <= ops_done + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed instruction sequences checked against a
// timestamp-based model every cycle, plus literal latency/handshake expectations.
module tb_regfile_sequencer;
    localparam int EXEC_LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = '0;
    logic [3:0] instr_imm = '0;
    logic [3:0] reg_a_d;
    logic [3:0] reg_b_d;
    logic       lda;
    logic       ldb;
    logic       ldo;
    logic [1:0] alu_op;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       err;
    logic [7:0] ops_done;
    logic [2:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    regfile_sequencer #(.EXEC_LAT(EXEC_LAT)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_imm(instr_imm),
        .reg_a_d(reg_a_d), .reg_b_d(reg_b_d),
        .lda(lda), .ldb(ldb), .ldo(ldo), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .ops_done(ops_done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Expected outputs after each edge, derived from accept times: an ALU op accepted
    // at edge t writes back at edge t+EXEC_LAT+1 and offers O from the edge after.
    logic       e_ready, e_lda, e_ldb, e_ldo, e_out_valid, e_err;
    logic [3:0] e_a, e_b;
    logic [1:0] e_alu;
    logic [7:0] e_ops;
    int         cyc = 0;
    int         wb_at = 0;
    bit         busy = 0;

    task automatic model_reset();
        e_ready = 0; e_lda = 0; e_ldb = 0; e_ldo = 0; e_out_valid = 0; e_err = 0;
        e_a = '0; e_b = '0; e_alu = '0; e_ops = '0;
        busy = 0; wb_at = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit taken;
        cyc++;
        acc   = instr_valid && e_ready;
        taken = e_out_valid && out_ready;
        e_lda = acc && (instr_op == 3'd1);
        e_ldb = acc && (instr_op == 3'd2);
        if (acc) begin
            case (instr_op)
                3'd1: e_a = instr_imm;
                3'd2: e_b = instr_imm;
                3'd3, 3'd4, 3'd5, 3'd6: begin
                    e_alu = 2'(instr_op - 3'd3);
                    busy  = 1;
                    wb_at = cyc + EXEC_LAT + 1;
                end
                3'd7: e_err = 1;
                default: ;
            endcase
        end
        e_ldo = busy && (cyc == wb_at);
        if (taken) begin
            e_ops       = e_ops + 8'd1;
            busy        = 0;
            e_out_valid = 0;
        end else begin
            e_out_valid = busy && (cyc > wb_at);
        end
        e_ready = !busy && !e_lda && !e_ldb;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && reset) begin
                check("cmp instr_ready", 32'(instr_ready), 32'(e_ready));
                check("cmp lda", 32'(lda), 32'(e_lda));
                check("cmp ldb", 32'(ldb), 32'(e_ldb));
                check("cmp ldo", 32'(ldo), 32'(e_ldo));
                check("cmp out_valid", 32'(out_valid), 32'(e_out_valid));
                check("cmp err", 32'(err), 32'(e_err));
                check("cmp ops_done", 32'(ops_done), 32'(e_ops));
                check("cmp reg_a_d", 32'(reg_a_d), 32'(e_a));
                check("cmp reg_b_d", 32'(reg_b_d), 32'(e_b));
                check("cmp alu_op", 32'(alu_op), 32'(e_alu));
            end
        end
    end

    // ---------------- driver ----------------
    // Presents one instruction and holds it until accepted; returns the accept edge index.
    task automatic send(input logic [2:0] op, input logic [3:0] imm, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_imm   = imm;
        while (!instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send timeout: instr_ready stayed 0, required 1 within 200 cycles");
        end
        acc = cyc + 1;
        @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0, a1, n;
        logic [2:0] op;

        repeat (3) @(negedge clk);
        check("rst instr_ready", 32'(instr_ready), 0);
        check("rst lda", 32'(lda), 0);
        check("rst ldb", 32'(ldb), 0);
        check("rst ldo", 32'(ldo), 0);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst err", 32'(err), 0);
        check("rst ops_done", 32'(ops_done), 0);
        check("rst reg_a_d", 32'(reg_a_d), 0);
        check("rst reg_b_d", 32'(reg_b_d), 0);
        check("rst alu_op", 32'(alu_op), 0);
        #2 reset = 1'b1;
        chk_on = 1;
        @(negedge clk);
        check("release instr_ready", 32'(instr_ready), 1);

        // Reset in the middle of EXEC abandons the ADD.
        send(3'd3, 4'h0, a0);
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t1 lda", 32'(lda), 0);
        check("t1 ldb", 32'(ldb), 0);
        check("t1 ldo", 32'(ldo), 0);
        check("t1 out_valid", 32'(out_valid), 0);
        check("t1 instr_ready in reset", 32'(instr_ready), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("t1 ready before edge", 32'(instr_ready), 0);
        @(negedge clk);
        check("t1 ready first edge", 32'(instr_ready), 1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (ldo) n++;
        end
        check("t1 no ldo after reset", n, 0);

        // LDA 5 then LDB 3 with valid held.
        send(3'd1, 4'h5, a0);
        @(negedge clk);
        check("t2 lda", 32'(lda), 1);
        check("t2 reg_a_d", 32'(reg_a_d), 5);
        check("t2 ldb during lda", 32'(ldb), 0);
        send(3'd2, 4'h3, a1);
        @(negedge clk); instr_valid = 1'b0;
        check("t2 ldb", 32'(ldb), 1);
        check("t2 reg_b_d", 32'(reg_b_d), 3);
        check("t2 lda during ldb", 32'(lda), 0);
        check("t2 accept spacing", a1 - a0, 2);

        // ADD with out_ready=1.
        check("t3 ops_done before", 32'(ops_done), 0);
        send(3'd3, 4'h0, a0);
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk); instr_valid = 1'b0;
        end while (!ldo && n < 50);
        check("t3 accept to ldo", n, 3);
        check("t3 out_valid with ldo", 32'(out_valid), 0);
        @(negedge clk);
        check("t3 out_valid", 32'(out_valid), 1);
        check("t3 ldo one cycle", 32'(ldo), 0);
        check("t3 ops_done pending", 32'(ops_done), 0);
        @(negedge clk);
        check("t3 out_valid drop", 32'(out_valid), 0);
        check("t3 ops_done after", 32'(ops_done), 1);
        check("t3 ready after", 32'(instr_ready), 1);

        // SUB with the consumer stalled.
        @(negedge clk); out_ready = 1'b0;
        send(3'd4, 4'h0, a0);
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk); instr_valid = 1'b0;
        end while (!out_valid && n < 50);
        check("t4 accept to out_valid", n, 4);
        check("t4 alu_op sub", 32'(alu_op), 1);
        repeat (5) begin
            @(negedge clk);
            check("t4 out_valid held", 32'(out_valid), 1);
            check("t4 ready low", 32'(instr_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 out_valid drop", 32'(out_valid), 0);
        check("t4 ops_done", 32'(ops_done), 2);
        check("t4 ready back", 32'(instr_ready), 1);

        // Illegal opcode then NOP, both with immediates that must be ignored.
        check("t5 err before", 32'(err), 0);
        send(3'd7, 4'hF, a0);
        send(3'd0, 4'hE, a1);
        @(negedge clk); instr_valid = 1'b0;
        check("t5 err set", 32'(err), 1);
        check("t5 back to back", a1 - a0, 1);
        check("t5 lda", 32'(lda), 0);
        check("t5 ldb", 32'(ldb), 0);
        check("t5 reg_a_d kept", 32'(reg_a_d), 5);
        check("t5 reg_b_d kept", 32'(reg_b_d), 3);
        repeat (3) @(negedge clk);
        check("t5 err sticky", 32'(err), 1);

        // 256 ALU ops from reset wrap ops_done back to 0.
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk);
        check("t6 err cleared", 32'(err), 0);
        check("t6 ops_done cleared", 32'(ops_done), 0);
        for (int i = 0; i < 256; i++) begin
            op = 3'(3 + $urandom_range(0, 3));
            send(op, 4'($urandom_range(0, 15)), a0);
        end
        @(negedge clk); instr_valid = 1'b0;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6 drained", 32'(instr_ready), 1);
        check("t6 ops_done wrap", 32'(ops_done), 0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
